// File: rtl/stepper_phase_decoder_if.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | stepper_phase_decoder_if : coil observation and motion report bus    |
// | Rev 1.0                                                            |
// +--------------------------------------------------------------------+
interface stepper_phase_decoder_if #(
  parameter int POS_WIDTH = 16
);
  logic [3:0]           coils;
  logic                 clear;
  logic                 step_pulse;
  logic                 dir;
  logic [POS_WIDTH-1:0] position;
  logic                 locked;
  logic                 fault;

  modport master (
    output coils, clear,
    input  step_pulse, dir, position, locked, fault
  );

  modport slave (
    input  coils, clear,
    output step_pulse, dir, position, locked, fault
  );
endinterface
`default_nettype wire

// File: rtl/stepper_phase_decoder.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | stepper_phase_decoder : recovers step/dir/position from coil drive  |
// | Rev 1.0                                                            |
// +--------------------------------------------------------------------+
module stepper_phase_decoder #(
  parameter int POS_WIDTH  = 16,
  parameter int FILTER_LEN = 2
) (
  input  wire logic            system1000,
  input  wire logic            system1000_rstn,
  stepper_phase_decoder_if.slave bus
);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_LOCKED = 2'd1,
    S_FAULT  = 2'd2
  } state_t;

  localparam logic [3:0]           c_filter_len = 4'(FILTER_LEN);
  localparam logic [POS_WIDTH-1:0] c_pos_one    = {{(POS_WIDTH-1){1'b0}}, 1'b1};

  logic [3:0]           r_sync1, r_sync2, r_prev, r_cnt, r_acc_pat;
  logic                 r_acc;
  logic                 w_changed, w_accept;
  logic [3:0]           w_cnt_next;

  state_t               r_state, w_state_next;
  logic [1:0]           r_phase, w_phase_next;
  logic [POS_WIDTH-1:0] r_position, w_position_next;
  logic                 r_dir, w_dir_next;
  logic                 r_step, w_step_next;
  logic                 w_is_phase, w_is_zero;
  logic [1:0]           w_idx;

  // Counter saturates at FILTER_LEN; acceptance fires only on the cycle it gets there.
  assign w_changed  = (r_sync2 != r_prev);
  assign w_cnt_next = w_changed ? 4'd1 :
                      (r_cnt >= c_filter_len) ? r_cnt : r_cnt + 4'd1;
  assign w_accept   = (w_cnt_next == c_filter_len) && (w_changed || (r_cnt != c_filter_len));

  always_ff @(posedge system1000 or negedge system1000_rstn) begin
    if (!system1000_rstn) begin
      r_sync1   <= 4'd0;
      r_sync2   <= 4'd0;
      r_prev    <= 4'd0;
      r_cnt     <= 4'd0;
      r_acc     <= 1'b0;
      r_acc_pat <= 4'd0;
    end else begin
      r_sync1   <= bus.coils;
      r_sync2   <= r_sync1;
      r_prev    <= r_sync2;
      r_cnt     <= w_cnt_next;
      r_acc     <= w_accept;
      r_acc_pat <= r_sync2;
    end
  end

  always_comb begin
    w_is_phase = 1'b1;
    w_idx      = 2'd0;
    case (r_acc_pat)
      4'b0001: w_idx = 2'd0;
      4'b0010: w_idx = 2'd1;
      4'b0100: w_idx = 2'd2;
      4'b1000: w_idx = 2'd3;
      default: w_is_phase = 1'b0;
    endcase
  end

  assign w_is_zero = (r_acc_pat == 4'd0);

  always_ff @(posedge system1000 or negedge system1000_rstn) begin
    if (!system1000_rstn) begin
      r_state    <= S_IDLE;
      r_phase    <= 2'd0;
      r_position <= '0;
      r_dir      <= 1'b0;
      r_step     <= 1'b0;
    end else begin
      r_state    <= w_state_next;
      r_phase    <= w_phase_next;
      r_position <= w_position_next;
      r_dir      <= w_dir_next;
      r_step     <= w_step_next;
    end
  end

  always_comb begin
    w_state_next    = r_state;
    w_phase_next    = r_phase;
    w_position_next = r_position;
    w_dir_next      = r_dir;
    w_step_next     = 1'b0;
    if (bus.clear) begin
      w_state_next    = S_IDLE;
      w_position_next = '0;
    end else if (r_acc) begin
      case (r_state)
        S_IDLE: begin
          if (w_is_phase) begin
            w_state_next = S_LOCKED;
            w_phase_next = w_idx;
          end else if (!w_is_zero) begin
            w_state_next = S_FAULT;
          end
        end
        S_LOCKED: begin
          if (w_is_zero) begin
            w_state_next = S_IDLE;
          end else if (!w_is_phase) begin
            w_state_next = S_FAULT;
          end else if (w_idx == r_phase + 2'd1) begin
            w_step_next     = 1'b1;
            w_dir_next      = 1'b1;
            w_position_next = r_position + c_pos_one;
            w_phase_next    = w_idx;
          end else if (w_idx == r_phase - 2'd1) begin
            w_step_next     = 1'b1;
            w_dir_next      = 1'b0;
            w_position_next = r_position - c_pos_one;
            w_phase_next    = w_idx;
          end else if (w_idx == r_phase + 2'd2) begin
            w_state_next = S_FAULT;
          end
          // Re-acceptance of the held phase (after a filtered glitch) is a no-op.
        end
        default: w_state_next = r_state;
      endcase
    end
  end

  assign bus.step_pulse = r_step;
  assign bus.dir        = r_dir;
  assign bus.position   = r_position;
  assign bus.locked     = (r_state == S_LOCKED);
  assign bus.fault      = (r_state == S_FAULT);

endmodule
`default_nettype wire

// File: tb/tb_stepper_phase_decoder.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | tb_stepper_phase_decoder : directed + random check vs pattern model |
// | Rev 1.0                                                            |
// +--------------------------------------------------------------------+
module tb_stepper_phase_decoder;

  logic       clk = 1'b0;
  logic       rstn = 1'b0;
  logic [3:0] coils = 4'd0;
  logic       clear = 1'b0;

  int n_assert = 0;
  int n_fail   = 0;
  int pulses16 = 0;
  int pulses4  = 0;

  // Model: one entry per accepted pattern, no cycle-level detail.
  int         m_state = 0;   // 0 idle, 1 locked, 2 fault
  int         m_phase = 0;
  int         m_pos   = 0;
  bit         m_dir   = 1'b0;
  int         m_pulses = 0;
  logic [3:0] m_last  = 4'd0;
  logic [3:0] cur_pat = 4'd0;
  logic [3:0] ill [11] = '{4'd3, 4'd5, 4'd6, 4'd7, 4'd9, 4'd10, 4'd11, 4'd12, 4'd13, 4'd14, 4'd15};

  stepper_phase_decoder_if #(.POS_WIDTH(16)) bus16 ();
  stepper_phase_decoder_if #(.POS_WIDTH(4))  bus4 ();

  assign bus16.coils = coils;
  assign bus16.clear = clear;
  assign bus4.coils  = coils;
  assign bus4.clear  = clear;

  stepper_phase_decoder #(.POS_WIDTH(16), .FILTER_LEN(2)) dut16 (
    .system1000(clk), .system1000_rstn(rstn), .bus(bus16));
  stepper_phase_decoder #(.POS_WIDTH(4), .FILTER_LEN(2)) dut4 (
    .system1000(clk), .system1000_rstn(rstn), .bus(bus4));

  always #5 clk = ~clk;

  always @(posedge clk) begin
    #2;
    if (bus16.step_pulse === 1'b1) pulses16++;
    if (bus4.step_pulse === 1'b1) pulses4++;
  end

  initial begin
    #500000;
    $display("FAIL watchdog expired observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic int onehot_idx(input logic [3:0] p);
    case (p)
      4'b0001: return 0;
      4'b0010: return 1;
      4'b0100: return 2;
      4'b1000: return 3;
      default: return -1;
    endcase
  endfunction

  task automatic model_accept(input logic [3:0] p);
    int idx;
    idx = onehot_idx(p);
    if (m_state == 0) begin
      if (idx >= 0) begin m_state = 1; m_phase = idx; end
      else if (p != 4'd0) m_state = 2;
    end else if (m_state == 1) begin
      if (p == 4'd0) m_state = 0;
      else if (idx < 0) m_state = 2;
      else if (idx == (m_phase + 1) % 4) begin
        m_pos++; m_dir = 1'b1; m_pulses++; m_phase = idx;
      end else if (idx == (m_phase + 3) % 4) begin
        m_pos--; m_dir = 1'b0; m_pulses++; m_phase = idx;
      end else if (idx == (m_phase + 2) % 4) m_state = 2;
    end
  endtask

  task automatic check_all(input string tag);
    chk({tag, ":locked16"}, 32'(bus16.locked), 32'(m_state == 1));
    chk({tag, ":fault16"},  32'(bus16.fault),  32'(m_state == 2));
    chk({tag, ":dir16"},    32'(bus16.dir),    32'(m_dir));
    chk({tag, ":pos16"},    32'(bus16.position), 32'(m_pos) & 32'hFFFF);
    chk({tag, ":pulses16"}, 32'(pulses16),     32'(m_pulses));
    chk({tag, ":locked4"},  32'(bus4.locked),  32'(m_state == 1));
    chk({tag, ":pos4"},     32'(bus4.position), 32'(m_pos) & 32'hF);
    chk({tag, ":pulses4"},  32'(pulses4),      32'(m_pulses));
  endtask

  // Starts and ends on a falling edge; hold counts rising edges.
  task automatic seg(input string tag, input logic [3:0] p, input int hold);
    coils = p;
    repeat (hold) @(negedge clk);
    if (hold >= 2 && p != m_last) model_accept(p);
    m_last = p;
    if (hold >= 5) begin
      cur_pat = p;
      check_all(tag);
    end
  endtask

  task automatic do_clear(input string tag);
    clear = 1'b1;
    @(negedge clk);
    clear = 1'b0;
    m_state = 0;
    m_pos   = 0;
    check_all(tag);
  endtask

  initial begin
    logic [3:0] nxt;
    int         r, idx;

    repeat (3) @(negedge clk);
    check_all("reset");
    rstn = 1'b1;
    repeat (4) @(negedge clk);

    // Latency: lock appears exactly at E0+4.
    coils = 4'b0001;
    repeat (4) @(negedge clk);
    chk("lat_e3_locked", 32'(bus16.locked), 32'd0);
    @(negedge clk);
    chk("lat_e4_locked", 32'(bus16.locked), 32'd1);
    repeat (5) @(negedge clk);
    model_accept(4'b0001);
    m_last = 4'b0001; cur_pat = 4'b0001;
    check_all("hold0001");

    seg("fwd1", 4'b0010, 5); seg("fwd2", 4'b0100, 5);
    seg("fwd3", 4'b1000, 5); seg("fwd4", 4'b0001, 5);
    chk("fwd_pos4", 32'(bus16.position), 32'd4);
    seg("bck1", 4'b1000, 5); seg("bck2", 4'b0100, 5);
    seg("bck3", 4'b0010, 5); seg("bck4", 4'b0001, 5);
    chk("bck_pos0", 32'(bus16.position), 32'd0);
    chk("bck_dir0", 32'(bus16.dir), 32'd0);

    // Skipped phase faults; inputs then ignored until clear.
    seg("opp", 4'b0100, 6);
    chk("opp_fault", 32'(bus16.fault), 32'd1);
    seg("fault_ign1", 4'b1000, 6);
    seg("fault_ign2", 4'b0001, 6);
    do_clear("clr_fault");
    repeat (5) @(negedge clk);
    check_all("clr_no_reaccept");

    seg("lock0010", 4'b0010, 6);
    seg("glitch", 4'b0110, 1);
    seg("glitch_ret", 4'b0010, 6);
    chk("glitch_nofault", 32'(bus16.fault), 32'd0);
    seg("step0100", 4'b0100, 6);

    // Clear on the same edge the step would land: step discarded, dir kept.
    coils = 4'b1000;
    repeat (4) @(negedge clk);
    clear = 1'b1;
    @(negedge clk);
    clear = 1'b0;
    m_last = 4'b1000; cur_pat = 4'b1000;
    m_state = 0; m_pos = 0;
    chk("clr_step_pulse", 32'(bus16.step_pulse), 32'd0);
    check_all("clr_step");
    repeat (3) @(negedge clk);
    check_all("clr_step_after");

    // Wrap on the 4-bit instance, and below zero on both.
    seg("wrap_lock", 4'b0001, 6);
    for (int i = 0; i < 8; i++) seg("wrap_fwd", 4'(1 << ((i + 1) % 4)), 5);
    chk("wrap4_8", 32'(bus4.position), 32'h8);
    for (int i = 0; i < 9; i++) seg("wrap_bck", 4'(1 << ((3 - (i % 4)) % 4)), 5);
    chk("neg16", 32'(bus16.position), 32'hFFFF);
    chk("neg4", 32'(bus4.position), 32'hF);
    seg("wrap_fwd0", 4'b0001, 5);
    seg("wrap_fwd1", 4'b0010, 5);

    // Asynchronous reset between edges.
    #2;
    rstn = 1'b0;
    coils = 4'd0;
    #1;
    m_state = 0; m_pos = 0; m_dir = 1'b0; m_last = 4'd0; cur_pat = 4'd0;
    check_all("async_rst");
    @(negedge clk);
    rstn = 1'b1;
    repeat (3) @(negedge clk);
    seg("post_rst_lock", 4'b0100, 6);
    seg("post_rst_step", 4'b1000, 6);

    for (int k = 0; k < 120; k++) begin
      if (m_state == 2) begin
        do_clear("rnd_clr");
        continue;
      end
      r   = $urandom_range(0, 99);
      idx = onehot_idx(cur_pat);
      if (idx < 0) idx = $urandom_range(0, 3);
      if (r < 40)      nxt = 4'(1 << ((idx + 1) % 4));
      else if (r < 70) nxt = 4'(1 << ((idx + 3) % 4));
      else if (r < 78) nxt = cur_pat;
      else if (r < 84) nxt = 4'd0;
      else if (r < 88) nxt = 4'(1 << ((idx + 2) % 4));
      else if (r < 92) nxt = ill[$urandom_range(0, 10)];
      else begin
        nxt = ill[$urandom_range(0, 10)];
        if (nxt != cur_pat) begin
          seg("rnd_glitch", nxt, 1);
          nxt = cur_pat;
        end
      end
      seg("rnd", nxt, $urandom_range(5, 7));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
